pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Consumes the load-use stall request from the hazard unit, branch redirect from Execute and data-memory ready from Memory. Drives per-stage enable/flush controls to the F/D/E/M/W pipeline registers. Owns the post-reset pipeline-clearing sequence and a data-memory wait watchdog.

Parameters:
INIT_CYCLES, 2, cycles after reset release spent clearing the pipeline before fetch starts (min 1)
MEM_TIMEOUT, 255, consecutive MemReadyM-low cycles before MemTimeout asserts (min 1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  load-use request from hazard unit (combinational, same cycle)
PCSrcE  input  1  branch/jump taken in Execute
MemReadyM  input  1  data memory ready; 0 = access in Memory not complete
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
StallE  output  1  hold ID/EX register
StallM  output  1  hold EX/MEM register
FlushD  output  1  clear IF/ID to bubble
FlushE  output  1  clear ID/EX to bubble
FlushW  output  1  clear MEM/WB to bubble
MemTimeout  output  1  sticky watchdog error
StallCycles  output  32  perf counter (PIPE_PERF_CNT_EN only)
FlushCycles  output  32  perf counter (PIPE_PERF_CNT_EN only)

Behaviour:
- States: INIT, RUN, MEM_WAIT. Control outputs are combinational from state plus inputs; state, counters, MemTimeout registered.
- rst=1 (any state, incl. mid-MEM_WAIT): next state INIT, init counter loaded INIT_CYCLES-1, wait counter 0, MemTimeout 0, perf counters 0. While rst=1 outputs forced: StallF=1, FlushD=FlushE=FlushW=1, StallD/E/M=0.
- INIT: outputs as during rst. Counter decrements each cycle; at 0 -> RUN. First instruction fetched exactly INIT_CYCLES cycles after rst falls. Inputs ignored in INIT.
- RUN/MEM_WAIT, per-cycle priority (first match wins):
  1. MemReadyM=0: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. State -> MEM_WAIT. PCSrcE and stall ignored (held in place, re-evaluated on release).
  2. PCSrcE=1: FlushD=FlushE=1, all stalls 0, FlushW=0.
  3. stall=1: StallF=StallD=1, FlushE=1; others 0.
  4. else all control outputs 0.
- MEM_WAIT -> RUN in the cycle after MemReadyM=1 is sampled; that release cycle already applies rules 2-4 combinationally (zero-cycle release latency).
- Wait counter: increments each cycle MemReadyM=0 in RUN/MEM_WAIT, clears when MemReadyM=1; saturates at MEM_TIMEOUT. On reaching MEM_TIMEOUT MemTimeout sets and stays set until rst. Pipeline keeps stalling; no auto-recovery.
- Width of wait counter: $clog2(MEM_TIMEOUT+1).

Optional Feature:
PIPE_PERF_CNT_EN: defined -> StallCycles increments each RUN/MEM_WAIT cycle with StallF=1; FlushCycles increments each RUN/MEM_WAIT cycle with FlushE=1; both 32-bit wrap-around, cleared by rst, not counted in INIT. Undefined -> ports present, tied to 0, no counter flops.

Test Plan:
- Reset release, INIT_CYCLES=2 -> StallF=1, FlushD=FlushE=1 for cycles 0-1 after rst falls; cycle 2 all outputs 0.
- stall=1 one cycle in RUN -> that cycle StallF=StallD=FlushE=1, StallE=StallM=0; next cycle with stall=0 all 0.
- PCSrcE=1 and stall=1 same cycle -> FlushD=FlushE=1, StallF=StallD=0.
- MemReadyM=0 for 3 cycles with PCSrcE=1 -> StallF/D/E/M=1, FlushW=1, FlushD=0 for 3 cycles; 4th cycle (MemReadyM=1) FlushD=FlushE=1.
- MEM_TIMEOUT=4, MemReadyM=0 held 6 cycles -> MemTimeout rises after 4th low cycle, stays 1 after MemReadyM returns; rst clears it; rst mid-wait -> INIT.
- PIPE_PERF_CNT_EN defined, 2 stall cycles + 1 branch flush -> StallCycles=2, FlushCycles=3; undefined -> both read 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bus: hazard/branch/memory status in, per-stage stall/flush out.
interface pipeline_ctrl_if;
   logic        stall;
   logic        PCSrcE;
   logic        MemReadyM;
   logic        StallF;
   logic        StallD;
   logic        StallE;
   logic        StallM;
   logic        FlushD;
   logic        FlushE;
   logic        FlushW;
   logic        MemTimeout;
   logic [31:0] StallCycles;
   logic [31:0] FlushCycles;

   // Sequencer side: consumes status, drives pipeline-register controls
   modport slave (
      input  stall, PCSrcE, MemReadyM,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      output MemTimeout, StallCycles, FlushCycles
   );

   // Pipeline side: supplies status, receives controls
   modport master (
      output stall, PCSrcE, MemReadyM,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      input  MemTimeout, StallCycles, FlushCycles
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: post-reset clearing,
// memory-wait stalls, branch flushes, load-use stalls and a memory watchdog.
// Optional macro PIPE_PERF_CNT_EN enables the StallCycles/FlushCycles counters.
module pipeline_ctrl #(
   parameter int unsigned INIT_CYCLES = 2,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   pipeline_ctrl_if.slave  bus
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                timeout_q, timeout_d;

   logic stall_f, stall_d, stall_e, stall_m;
   logic flush_d, flush_e, flush_w;
   logic active_c;

   // State, init/wait counters and sticky watchdog flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         init_cnt_q <= INIT_W'(INIT_CYCLES - 1);
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next state and per-cycle stall/flush controls (priority: mem wait, branch, load-use)
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      stall_e    = 1'b0;
      stall_m    = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      flush_w    = 1'b0;
      active_c   = 1'b0;

      case (state_q)
         ST_INIT: begin
            stall_f = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
            if (init_cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               init_cnt_d = init_cnt_q - INIT_W'(1);
            end
         end
         ST_RUN, ST_MEM_WAIT: begin
            active_c = 1'b1;
            if (!bus.MemReadyM) begin
               // Freeze everything up to Memory; bubble into Writeback
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               stall_m = 1'b1;
               flush_w = 1'b1;
               state_d = ST_MEM_WAIT;
               if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT)) begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
               if (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)) begin
                  timeout_d = 1'b1;
               end
            end else begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
               if (bus.PCSrcE) begin
                  flush_d = 1'b1;
                  flush_e = 1'b1;
               end else if (bus.stall) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  flush_e = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      // Reset forces the clearing pattern regardless of state
      if (rst) begin
         stall_f  = 1'b1;
         stall_d  = 1'b0;
         stall_e  = 1'b0;
         stall_m  = 1'b0;
         flush_d  = 1'b1;
         flush_e  = 1'b1;
         flush_w  = 1'b1;
         active_c = 1'b0;
      end
   end

   assign bus.StallF     = stall_f;
   assign bus.StallD     = stall_d;
   assign bus.StallE     = stall_e;
   assign bus.StallM     = stall_m;
   assign bus.FlushD     = flush_d;
   assign bus.FlushE     = flush_e;
   assign bus.FlushW     = flush_w;
   assign bus.MemTimeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] flush_cycles_q;

   // Wrap-around perf counters over active (non-INIT) cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         flush_cycles_q <= '0;
      end else if (active_c) begin
         if (stall_f) stall_cycles_q <= stall_cycles_q + 32'(1);
         if (flush_e) flush_cycles_q <= flush_cycles_q + 32'(1);
      end
   end

   assign bus.StallCycles = stall_cycles_q;
   assign bus.FlushCycles = flush_cycles_q;
`else
   assign bus.StallCycles = 32'd0;
   assign bus.FlushCycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (INIT_CYCLES=2, MEM_TIMEOUT=4).
module tb_pipeline_ctrl;

   // Control vector order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
   localparam logic [6:0] C_INIT   = 7'b1000111;
   localparam logic [6:0] C_IDLE   = 7'b0000000;
   localparam logic [6:0] C_STALL  = 7'b1100010;
   localparam logic [6:0] C_BRANCH = 7'b0000110;
   localparam logic [6:0] C_MEM    = 7'b1111001;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pipeline_ctrl_if u_if ();

   pipeline_ctrl #(
      .INIT_CYCLES (2),
      .MEM_TIMEOUT (4)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] ctrl_vec();
      return {u_if.StallF, u_if.StallD, u_if.StallE, u_if.StallM,
              u_if.FlushD, u_if.FlushE, u_if.FlushW};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs after the active edge; return at mid-cycle for sampling
   task automatic step(input logic r, input logic s, input logic p, input logic m);
      @(posedge clk);
      #1;
      rst            = r;
      u_if.stall     = s;
      u_if.PCSrcE    = p;
      u_if.MemReadyM = m;
      @(negedge clk);
   endtask

   task automatic chk_ctrl(input string tag, input logic [6:0] exp);
      chk(tag, 32'(ctrl_vec()), 32'(exp));
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b1;
      u_if.stall     = 1'b0;
      u_if.PCSrcE    = 1'b0;
      u_if.MemReadyM = 1'b1;

      // Reset: clearing pattern forced regardless of inputs
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk_ctrl("rst_ctrl", C_INIT);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk_ctrl("rst_ctrl_inputs", C_INIT);
      chk("rst_timeout", 32'(u_if.MemTimeout), 32'd0);

      // Two INIT cycles after release, then fetch starts
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_ctrl("init_c0", C_INIT);
      chk("init_stallcnt", u_if.StallCycles, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk_ctrl("init_c1_ignores_stall", C_INIT);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_ctrl("run_c2_idle", C_IDLE);

      // Load-use stall, branch priority over stall
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk_ctrl("stall_1", C_STALL);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_ctrl("after_stall", C_IDLE);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk_ctrl("stall_2", C_STALL);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk_ctrl("branch_over_stall", C_BRANCH);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_ctrl("after_branch", C_IDLE);
`ifdef PIPE_PERF_CNT_EN
      chk("perf_stall", u_if.StallCycles, 32'd2);
      chk("perf_flush", u_if.FlushCycles, 32'd3);
`else
      chk("perf_stall_off", u_if.StallCycles, 32'd0);
      chk("perf_flush_off", u_if.FlushCycles, 32'd0);
`endif

      // Memory wait masks a pending branch; branch applies on release cycle
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0);
         chk_ctrl($sformatf("memwait_%0d", i), C_MEM);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk_ctrl("mem_release_branch", C_BRANCH);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_ctrl("post_release_idle", C_IDLE);
      chk("no_timeout_short_wait", 32'(u_if.MemTimeout), 32'd0);

      // Watchdog: rises after the 4th consecutive low cycle, sticky
      for (int i = 1; i <= 6; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         chk_ctrl($sformatf("wd_ctrl_%0d", i), C_MEM);
         chk($sformatf("wd_timeout_%0d", i), 32'(u_if.MemTimeout), (i >= 5) ? 32'd1 : 32'd0);
      end
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk_ctrl("wd_release_stall", C_STALL);
      chk("wd_sticky_1", 32'(u_if.MemTimeout), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("wd_sticky_2", 32'(u_if.MemTimeout), 32'd1);

      // Reset clears the watchdog
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("wd_during_rst", 32'(u_if.MemTimeout), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("wd_cleared", 32'(u_if.MemTimeout), 32'd0);
      chk_ctrl("rerun_init_c0", C_INIT);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_ctrl("rerun_init_c1", C_INIT);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_ctrl("rerun_idle", C_IDLE);

      // Reset in the middle of a memory wait returns to INIT
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk_ctrl("midwait_0", C_MEM);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk_ctrl("midwait_1", C_MEM);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk_ctrl("midwait_rst", C_INIT);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk_ctrl("midwait_init_c0", C_INIT);
      chk("midwait_perf_stall_clr", u_if.StallCycles, 32'd0);
      chk("midwait_perf_flush_clr", u_if.FlushCycles, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_ctrl("midwait_init_c1", C_INIT);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_ctrl("midwait_run_idle", C_IDLE);
      chk("midwait_timeout", 32'(u_if.MemTimeout), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
